prog_loader_mem: RTL

PROG_LOADER_MEM -- requirements
Module: prog_loader_mem

---
 rtl/prog_loader_mem.sv | 112 +++++++++++
 1 files changed

// File: rtl/prog_loader_mem.sv
// Program loader and CPU boot memory: streams bytes into a RAM, holds the CPU
// in reset for HOLD_CYC cycles after the load, then serves combinational reads.
module prog_loader_mem #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic              clk_ph1,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  input  logic [15:0]       Addr_bus,
  output logic [7:0]        Data_bus,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   ld_count,
  output logic              ovf
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HOLD_W = 4;

  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC);

  typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_d;
  logic               ovf_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               wr_c;

  logic [7:0] mem [DEPTH];

  // State and registered outputs
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD;
      ld_count <= '0;
      ovf      <= 1'b0;
      hold_q   <= HOLD_INIT;
      ld_ready <= 1'b1;
      cpu_rst  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_count <= count_d;
      ovf      <= ovf_d;
      hold_q   <= hold_d;
      ld_ready <= (state_d == LOAD);
      cpu_rst  <= (state_d == RUN);
    end
  end

  // Next-state logic; reload overrides everything including a coincident handshake
  always_comb begin
    state_d = state_q;
    count_d = ld_count;
    ovf_d   = ovf;
    hold_d  = hold_q;
    wr_c    = 1'b0;
    if (reload) begin
      state_d = LOAD;
      count_d = '0;
      ovf_d   = 1'b0;
      hold_d  = HOLD_INIT;
    end else begin
      case (state_q)
        LOAD: begin
          if (ld_valid && (ld_count != FULL)) begin
            wr_c    = 1'b1;
            count_d = ld_count + CNT_W'(1);
            if (ld_last) begin
              state_d = HOLD;
              hold_d  = HOLD_INIT;
            end else if (ld_count == LAST_ADDR) begin
              state_d = HOLD;
              hold_d  = HOLD_INIT;
              ovf_d   = 1'b1;
            end
          end
        end
        HOLD: begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q <= HOLD_W'(1)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  // Program RAM: never cleared, stale bytes hidden by the ld_count gate
  always_ff @(posedge clk_ph1) begin
    if (wr_c) begin
      mem[ld_count[ADDR_W-1:0]] <= ld_data;
    end
  end

  assign Data_bus = ((state_q == RUN) && (32'(Addr_bus) < 32'(ld_count)))
                    ? mem[Addr_bus[ADDR_W-1:0]] : 8'h00;

endmodule
